// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state type and constants for the imem loader
package loader_pkg;
   typedef enum logic [2:0] {IDLE, COUNT, DATA, CSUM, DONE, ERR} ldr_state_t;
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in / imem write port out, as seen by the loader
interface imem_loader_if #(
   parameter int ADDR_W = 32
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wd;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, mem_we, mem_addr, mem_wd
   );
   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, mem_we, mem_addr, mem_wd
   );
endinterface

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs four bytes into a little-endian word
module byte_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_out,
   output logic        word_valid
);
   logic [23:0] lanes_q, lanes_d;
   logic [1:0]  idx_q, idx_d;

   always_comb begin
      lanes_d = lanes_q;
      idx_d   = idx_q;
      if (clr) begin
         idx_d = 2'd0;
      end else if (byte_en) begin
         case (idx_q)
            2'd0:    lanes_d[7:0]   = byte_in;
            2'd1:    lanes_d[15:8]  = byte_in;
            2'd2:    lanes_d[23:16] = byte_in;
            default: lanes_d        = lanes_q;
         endcase
         idx_d = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lanes_q <= '0;
         idx_q   <= '0;
      end else begin
         lanes_q <= lanes_d;
         idx_q   <= idx_d;
      end
   end

   // The fourth byte is presented combinationally so the write lands one cycle after it.
   assign word_out   = {byte_in, lanes_q};
   assign word_valid = byte_en && !clr && (idx_q == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - frames a byte stream into imem words and gates the core reset
module imem_loader
   import loader_pkg::*;
#(
   parameter int         DEPTH  = 64,
   parameter int         ADDR_W = 32,
   parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   imem_loader_if.master     bus,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_err,
   output logic [7:0]        words_loaded
);
   ldr_state_t        state_q;
   logic              rx_ready_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wd_q;
   logic              cpu_reset_q, load_done_q, load_err_q;
   logic [7:0]        n_q, csum_q, words_q;

   logic        accept, is_sync, count_ok, pk_valid;
   logic [31:0] pk_word;

   assign accept   = bus.rx_valid && rx_ready_q;
   assign is_sync  = (bus.rx_data == SYNC);
   assign count_ok = (bus.rx_data != 8'd0) && (32'(bus.rx_data) <= 32'(DEPTH));

   byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clr        (accept && (state_q == COUNT)),
      .byte_en    (accept && (state_q == DATA)),
      .byte_in    (bus.rx_data),
      .word_out   (pk_word),
      .word_valid (pk_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rx_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wd_q    <= '0;
         cpu_reset_q <= 1'b1;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         n_q         <= '0;
         csum_q      <= '0;
         words_q     <= '0;
      end else begin
         rx_ready_q <= 1'b1;
         mem_we_q   <= 1'b0;
         if (accept) begin
            case (state_q)
               IDLE: if (is_sync) state_q <= COUNT;
               COUNT: begin
                  if (!count_ok) begin
                     state_q    <= ERR;
                     load_err_q <= 1'b1;
                  end else begin
                     n_q     <= bus.rx_data;
                     csum_q  <= '0;
                     words_q <= '0;
                     state_q <= DATA;
                  end
               end
               DATA: begin
                  csum_q <= csum_q ^ bus.rx_data;
                  if (pk_valid) begin
                     mem_we_q   <= 1'b1;
                     mem_wd_q   <= pk_word;
                     mem_addr_q <= ADDR_W'({words_q, 2'b00});
                     words_q    <= words_q + 8'd1;
                     if (words_q + 8'd1 == n_q) state_q <= CSUM;
                  end
               end
               CSUM: begin
                  if (bus.rx_data == csum_q) begin
                     state_q     <= DONE;
                     cpu_reset_q <= 1'b0;
                     load_done_q <= 1'b1;
                  end else begin
                     state_q    <= ERR;
                     load_err_q <= 1'b1;
                  end
               end
               // Only a SYNC byte leaves a terminal state; it starts a fresh frame.
               DONE, ERR: begin
                  if (is_sync) begin
                     state_q     <= COUNT;
                     cpu_reset_q <= 1'b1;
                     load_done_q <= 1'b0;
                     load_err_q  <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.rx_ready  = rx_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wd    = mem_wd_q;
   assign cpu_reset     = cpu_reset_q;
   assign load_done     = load_done_q;
   assign load_err      = load_err_q;
   assign words_loaded  = words_q;
endmodule
